// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: boot-time loader that owns the instruction-memory write
// port while the core is held in reset. It receives a little-endian byte
// stream made of a 32-bit word count followed by that many 32-bit
// instructions. Each instruction is written to consecutive word addresses,
// and the core is released once the last word has been written.
module imem_loader_ctrl #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_din,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  byte_idx;     // lane of the next byte; wraps 3 -> 0
  logic [23:0] asm_q;        // lanes 0..2 of the field being assembled
  logic [31:0] len;          // program length in words
  logic [31:0] word_idx;     // index of the word currently being loaded
  logic        accept;
  logic        last_byte;
  logic [31:0] word_full;
  logic [31:0] word_idx_inc;

  // The receiver may only push bytes while a header or data word is being collected.
  assign rx_ready     = (state == S_HDR) || (state == S_DATA);
  assign accept       = rx_valid && rx_ready;
  assign last_byte    = accept && (byte_idx == 2'd3);
  // The 4th byte completes the field directly from the bus, so no extra cycle is spent.
  assign word_full    = {rx_data, asm_q};
  assign word_idx_inc = word_idx + 32'd1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block evaluation order.
    if (rst) state <= S_HDR;
    else     state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      S_HDR: begin
        if (last_byte) begin
          if (word_full == 32'd0)                   state_next = S_DONE;
          else if (word_full > 32'(MAX_WORDS))      state_next = S_ERR;
          else                                      state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        if (word_idx_inc == len) state_next = S_DONE;
        else                     state_next = S_DATA;
      end
      S_DONE:  state_next = S_DONE;
      S_ERR:   state_next = S_ERR;
      default: state_next = S_HDR;
    endcase
  end

  // Byte assembly, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the assembly register is reset too, so a reset mid-word leaves
      // no stale lanes behind; it is only a few flops, not a memory array.
      byte_idx  <= 2'd0;
      asm_q     <= 24'd0;
      len       <= 32'd0;
      word_idx  <= 32'd0;
      imem_we   <= 1'b0;
      imem_addr <= 32'd0;
      imem_din  <= 32'd0;
      core_rst  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        case (byte_idx)
          2'd0:    asm_q[7:0]   <= rx_data;
          2'd1:    asm_q[15:8]  <= rx_data;
          2'd2:    asm_q[23:16] <= rx_data;
          default: ;
        endcase
      end

      if ((state == S_HDR) && last_byte) begin
        len      <= word_full;
        word_idx <= 32'd0;
      end

      if (state == S_WRITE) word_idx <= word_idx_inc;

      // Address and data are captured as the word completes and hold afterwards.
      if ((state == S_DATA) && last_byte) begin
        imem_addr <= {word_idx[29:0], 2'b00};
        imem_din  <= word_full;
      end

      // Status outputs are registered copies of the state being entered.
      imem_we   <= (state_next == S_WRITE);
      core_rst  <= (state_next != S_DONE);
      load_done <= (state_next == S_DONE);
      load_err  <= (state_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Testbench for imem_loader_ctrl: byte streams with random gaps are fed in,
// the observed writes and status are compared with a stream-level reference
// model, and per-cycle handshake/timing rules are watched by a monitor.
module tb_imem_loader_ctrl;

  localparam int unsigned MAXW = 4;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;
  logic        core_rst;
  logic        load_done;
  logic        load_err;

  imem_loader_ctrl #(.MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .core_rst  (core_rst),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          n_acc;
  int          last_acc;
  int          last_we;
  int          done_cyc;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collect writes and byte transfers; enforce per-cycle handshake rules.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      n_acc    = 0;
      last_acc = -100;
      last_we  = -100;
      done_cyc = -1;
      wr_addr.delete();
      wr_data.delete();
    end else begin
      if (imem_we === 1'b1) begin
        check("we_rx_ready_low", 32'(rx_ready), 32'd0);
        check("we_one_after_byte", 32'(cyc - last_acc), 32'd1);
        check("we_byte_count", 32'(n_acc), 32'(4 + 4 * (wr_addr.size() + 1)));
        check("we_not_back_to_back", 32'(cyc - last_we > 1), 32'd1);
        wr_addr.push_back(imem_addr);
        wr_data.push_back(imem_din);
        last_we = cyc;
      end
      if (core_rst === 1'b0 && done_cyc < 0) done_cyc = cyc;
      if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
        n_acc++;
        last_acc = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] exp_len;
  logic        exp_err;
  logic        exp_done;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];

  // Expected outcome of a whole stream: header, then word i lands at byte address 4*i.
  task automatic build_model(input byte_q_t s);
    exp_addr.delete();
    exp_data.delete();
    exp_len  = {s[3], s[2], s[1], s[0]};
    exp_err  = (exp_len > 32'(MAXW));
    exp_done = 1'b0;
    if (!exp_err) begin
      for (int i = 0; i < int'(exp_len) && (4 * i + 7) < s.size(); i++) begin
        exp_addr.push_back(32'(4 * i));
        exp_data.push_back({s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]});
      end
      exp_done = (exp_addr.size() == int'(exp_len));
    end
  endtask

  function automatic byte_q_t le_bytes(input logic [31:0] w);
    le_bytes = {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rst_we"},    32'(imem_we),   32'd0);
    check({name, "_rst_addr"},  imem_addr,      32'd0);
    check({name, "_rst_din"},   imem_din,       32'd0);
    check({name, "_rst_core"},  32'(core_rst),  32'd1);
    check({name, "_rst_done"},  32'(load_done), 32'd0);
    check({name, "_rst_err"},   32'(load_err),  32'd0);
    check({name, "_rst_ready"}, 32'(rx_ready),  32'd1);
  endtask

  // Push each byte with a random idle gap before it; hold it until accepted.
  task automatic send_bytes(input byte_q_t b, input int max_gap);
    foreach (b[i]) begin
      int  gap;
      bit  ok;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_data  = b[i];
      ok = 1'b0;
      for (int w = 0; w < 50 && !ok; w++) begin
        @(negedge clk);
        ok = rx_ready;
        @(posedge clk);
        #1;
      end
      if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    end
    rx_valid = 1'b0;
  endtask

  // Offer bytes that must be refused.
  task automatic offer_refused(input int n);
    repeat (n) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      @(negedge clk);
      check("ready_closed", 32'(rx_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input string name, input byte_q_t s, input int max_gap, input bit with_reset);
    int n_send;
    build_model(s);
    if (with_reset) do_reset();
    n_send = (exp_err || exp_len == 32'd0) ? 4 : 4 + 4 * int'(exp_len);
    if (n_send > s.size()) n_send = s.size();
    send_bytes(s[0:n_send-1], max_gap);
    offer_refused(s.size() - n_send + 2);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_n_writes"}, 32'(wr_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), wr_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", name, i), wr_data[i], exp_data[i]);
    end
    check({name, "_bytes_taken"}, 32'(n_acc), 32'(n_send));
    check({name, "_load_done"},   32'(load_done), 32'(exp_done));
    check({name, "_load_err"},    32'(load_err),  32'(exp_err));
    check({name, "_core_rst"},    32'(core_rst),  32'(!exp_done));
    if (exp_err)                 check({name, "_core_held"},  32'(done_cyc), 32'hFFFF_FFFF);
    else if (exp_len == 32'd0)   check({name, "_done_lat"},   32'(done_cyc - last_acc), 32'd1);
    else if (exp_done)           check({name, "_release_lat"}, 32'(done_cyc - last_we), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    byte_q_t s;
    byte_q_t two_word;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    two_word = {8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h80, 8'h3E,
                8'h13, 8'h01, 8'h00, 8'h83};

    do_reset();
    check_reset_values("init");

    run_load("two_word", two_word, 0, 1'b1);

    s = {8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55, 8'h12};
    run_load("empty", s, 0, 1'b1);

    s = {8'h05, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    run_load("overflow", s, 0, 1'b1);

    run_load("backpressure", two_word, 7, 1'b1);

    s = {8'h04, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) s.push_back(8'($urandom));
    run_load("boundary", s, 3, 1'b1);

    s = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};
    run_load("len_all_ones", s, 2, 1'b1);

    // Reset after the 2nd byte of word 1 of a 3-word load.
    do_reset();
    s = le_bytes(32'd3);
    for (int i = 0; i < 3; i++) s = {s, le_bytes($urandom)};
    send_bytes(s[0:9], 0);
    check("mid_writes_before_rst", 32'(wr_addr.size()), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("mid");
    s = {8'h01, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
    run_load("fresh", s, 0, 1'b0);

    // Random legal programs and random oversized headers.
    for (int t = 0; t < 6; t++) begin
      s = le_bytes(32'($urandom_range(MAXW, 1)));
      for (int i = 0; i < int'(MAXW); i++) s = {s, le_bytes($urandom)};
      run_load($sformatf("rand%0d", t), s, int'($urandom_range(7, 0)), 1'b1);
    end
    for (int t = 0; t < 2; t++) begin
      s = le_bytes(32'($urandom_range(32'hFFFF, MAXW + 1)));
      s = {s, le_bytes($urandom)};
      run_load($sformatf("rand_err%0d", t), s, 2, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so a stuck handshake cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Boot-time controller that owns the instruction-memory write port while the core is held in reset. It accepts a byte stream (UART receiver side) carrying a 32-bit word count followed by that many 32-bit instructions, assembles each instruction, writes it to consecutive word-aligned instruction-memory addresses, and then releases the core. It replaces the fixed-table instruction generator with a runtime-loadable program source at the same memory port.

## Interface

- `MAX_WORDS`, default 1024: largest accepted program length in words. Longer headers are rejected.
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `rx_valid` input 1: `rx_data` holds a byte this cycle.
- `rx_data` input 8: stream byte.
- `rx_ready` output 1: controller accepts the byte this cycle. A byte transfers on `rx_valid && rx_ready`.
- `imem_we` output 1: single-cycle write strobe to instruction memory.
- `imem_addr` output 32: byte address. Always a multiple of 4.
- `imem_din` output 32: instruction word to write.
- `core_rst` output 1: holds the core in reset. High until the load completes.
- `load_done` output 1: program fully written. Sticky until `rst`.
- `load_err` output 1: header exceeded `MAX_WORDS`. Sticky until `rst`.

## Operation

- States: HDR, DATA, WRITE, DONE, ERR. Reset enters HDR.
- `rx_ready` is a pure function of state: 1 in HDR and DATA, 0 in WRITE, DONE and ERR.
- Byte order is little-endian throughout. The first byte of a field goes to bits [7:0] and the fourth to bits [31:24]. A 2-bit byte index selects the lane and wraps 3 to 0.
- **HDR:** collect 4 bytes into `len`.
  - On the 4th byte, if `len == 0`, go to DONE.
  - Else if `len > MAX_WORDS`, go to ERR.
  - Else go to DATA with `word_idx = 0`.
- **DATA:** collect 4 bytes into the assembly register. On the 4th byte, go to WRITE.
- **WRITE:** one cycle only.
  - Outputs: `imem_we = 1`, `imem_addr = word_idx << 2`, `imem_din` = assembled word.
  - `word_idx` increments.
  - If the incremented value equals `len`, go to DONE; else return to DATA.
- **DONE:** `core_rst = 0`, `load_done = 1`. No exit except `rst`. Further bytes are not accepted.
- **ERR:** `core_rst = 1`, `load_err = 1`, no writes. No exit except `rst`.
- Width rules:
  - `len` and `word_idx` are 32 bits.
  - The comparison against `MAX_WORDS` is unsigned over the full 32 bits, so `len = 0xFFFFFFFF` goes to ERR.
  - `imem_addr` is `word_idx` shifted left by 2, truncated to 32 bits. No wrap is reachable because `len <= MAX_WORDS`.

## Timing

- All outputs are registered, except `rx_ready` (decoded from the state register).
- Reset values: `imem_we = 0`, `imem_addr = 0`, `imem_din = 0`, `core_rst = 1`, `load_done = 0`, `load_err = 0`. `rx_ready` is 1 in the cycle after reset.
- `rst` has priority over every other event, including `rst` arriving mid-word or in WRITE. After reset, all partial bytes, `len` and `word_idx` are discarded and loading restarts at HDR.
- If the 4th byte of a word is accepted in cycle n:
  - `imem_we` is high in cycle n+1 only.
  - `rx_ready` is 0 in n+1.
  - The next byte can be accepted at the earliest in n+2.
- Sustained throughput is 1 word per 5 cycles.
- Last write in cycle m: `core_rst` falls and `load_done` rises in cycle m+1.
- Header with `len = 0` completing in cycle n: DONE from n+1, no `imem_we` pulse.
- Header with `len > MAX_WORDS` completing in cycle n: `load_err = 1` from n+1.
- Gaps in `rx_valid` (`rx_valid = 0`) stall the state without changing byte index or data. Any gap length is legal.
- `imem_addr` and `imem_din` hold their last values outside WRITE. Only `imem_we` qualifies them.

## Test plan

- **Two-word load:** stream `02 00 00 00 93 00 80 3E 13 01 00 83`, `rx_valid` held high.
  - Exactly two `imem_we` pulses: addr 0 / `0x3E800093`, then addr 4 / `0x83000113`.
  - `core_rst` falls the cycle after the second pulse and `load_done = 1`.
- **Empty program:** stream `00 00 00 00`.
  - No `imem_we` pulse.
  - `core_rst = 0` and `load_done = 1` one cycle after the 4th byte.
  - Extra bytes see `rx_ready = 0`.
- **Overflow:** `MAX_WORDS = 4`, header `05 00 00 00`.
  - `load_err = 1` and `core_rst` stays 1.
  - No `imem_we` pulse ever occurs, even with data bytes following.
- **Backpressure:** the two-word stream of the first scenario, with `rx_valid` randomly low 0–7 cycles between bytes.
  - Identical writes and final state.
  - `rx_ready = 0` in each WRITE cycle, and a byte offered then is not consumed.
- **Reset mid-load:** assert `rst` for 1 cycle after the 2nd byte of word 1 (addr 4) of a 3-word load.
  - All outputs return to reset values, with `core_rst = 1`.
  - A fresh one-word stream `01 00 00 00 13 05 00 00` then writes `0x00000513` to addr 0 and completes.
- **Boundary length:** `MAX_WORDS = 4`, header `04 00 00 00` plus 16 data bytes.
  - Four writes at addrs 0, 4, 8, 12.
  - `load_err = 0` and `load_done = 1`.
